// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the cycle-accurate SRAM responder.
package sram_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_READ_LAT  = 6;
    localparam int unsigned DEF_WRITE_LAT = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } state_e;

    // Counter holds LAT-1 at most; keep at least one bit for the LAT==1 build.
    function automatic int unsigned cnt_width(input int unsigned rd_lat,
                                              input int unsigned wr_lat);
        int unsigned max_lat;
        max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return (max_lat < 2) ? 1 : $clog2(max_lat);
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word storage: synchronous write, registered read. Contents are never reset;
// only the read register is cleared by rst.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Device side of the MEM-stage SRAM protocol: latches one request, waits a fixed latency,
// then pulses ack for one cycle with read data held until the next read completes.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned READ_LAT  = DEF_READ_LAT,
    parameter int unsigned WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(READ_LAT, WRITE_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_n_q, we_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    int unsigned       lat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_n_d  = we_n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        lat     = we_n ? READ_LAT : WRITE_LAT;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_n_d  = we_n;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(lat - 1);
                    state_d = (lat == 1) ? S_ACK : S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // busy tracks the state register exactly, so it drops in the ack cycle.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_n_q  <= we_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Array access happens on the edge that leaves S_ACK, so data lands with ack.
    sram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   ((state_q == S_ACK) && !we_n_q && !rst),
        .re   ((state_q == S_ACK) && we_n_q && !rst),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(rdata)
    );

    assign ack  = ack_q;
    assign busy = busy_q;

endmodule
